// File: rtl/fp32_to_fixed_if.sv
// Handshake bundle between the fp32->fixed converter and its producer/consumer.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid && ready; the
// source holds its payload stable and keeps valid high until that edge, and the sink may drive ready freely.
interface fp32_to_fixed_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_float;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_fixed;
  logic [3:0]   out_flags;

  modport master (
    output in_valid, in_float, out_ready,
    input  in_ready, out_valid, out_fixed, out_flags
  );

  modport slave (
    input  in_valid, in_float, out_ready,
    output in_ready, out_valid, out_fixed, out_flags
  );
endinterface

// File: rtl/fp32_to_fixed.sv
// Iterative IEEE754 single -> signed Q(INT_W).(FRAC_W) converter, one shift bit per cycle.
// Define ROUND_NEAREST_EN for round-to-nearest-even; otherwise the magnitude is truncated toward zero.
module fp32_to_fixed #(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  fp32_to_fixed_if.slave   bus_io,
  output logic [2:0]       dbg_state_o
);
  localparam int W  = INT_W + FRAC_W;
  // One spare bit above max(W,24) holds the rounding carry.
  localparam int AW = ((W > 24) ? W : 24) + 1;
  localparam logic signed [10:0] FRAC_S  = 11'(FRAC_W);
  localparam logic signed [10:0] INT_LIM = 11'(INT_W - 1);
  localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_MAX = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_SHIFT, S_PACK, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   f_q, f_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [7:0]    k_q, k_d;
  logic          left_q, left_d;
  logic          guard_q, guard_d;
  logic          sticky_q, sticky_d;
  logic          spec_q, spec_d;
  logic [W-1:0]  spec_fixed_q, spec_fixed_d;
  logic [3:0]    spec_flags_q, spec_flags_d;
  logic [W-1:0]  fixed_q, fixed_d;
  logic [3:0]    flags_q, flags_d;

  logic                sign;
  logic [7:0]          exp_f;
  logic [22:0]         mant;
  logic signed [10:0]  e_unb;
  logic signed [10:0]  s_val;
  logic signed [10:0]  neg_s;
  logic [W-1:0]        sat_val;
  logic                rnd;
  logic [AW-1:0]       mag_r;
  logic [AW-1:0]       lim;

  assign sign    = f_q[31];
  assign exp_f   = f_q[30:23];
  assign mant    = f_q[22:0];
  assign e_unb   = $signed({3'b000, exp_f}) - 11'sd127;
  assign s_val   = $signed({3'b000, exp_f}) - 11'sd150 + FRAC_S;
  assign neg_s   = -s_val;
  assign sat_val = sign ? NEG_MAX : POS_MAX;

`ifdef ROUND_NEAREST_EN
  assign rnd = guard_q && (sticky_q || acc_q[0]);
`else
  assign rnd = 1'b0;
`endif

  assign mag_r = acc_q + {{(AW-1){1'b0}}, rnd};
  // A negative result may reach -2^(W-1); a positive one stops at 2^(W-1)-1.
  assign lim   = sign ? AW'(NEG_MAX) : AW'(POS_MAX);

  assign bus_io.in_ready  = (state_q == S_IDLE);
  assign bus_io.out_valid = (state_q == S_DONE);
  assign bus_io.out_fixed = fixed_q;
  assign bus_io.out_flags = flags_q;
  assign dbg_state_o      = state_q;

  always_comb begin
    state_d      = state_q;
    f_d          = f_q;
    acc_d        = acc_q;
    k_d          = k_q;
    left_d       = left_q;
    guard_d      = guard_q;
    sticky_d     = sticky_q;
    spec_d       = spec_q;
    spec_fixed_d = spec_fixed_q;
    spec_flags_d = spec_flags_q;
    fixed_d      = fixed_q;
    flags_d      = flags_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus_io.in_valid) begin
          f_d     = bus_io.in_float;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        spec_d       = 1'b1;
        spec_fixed_d = '0;
        spec_flags_d = 4'b0000;
        guard_d      = 1'b0;
        sticky_d     = 1'b0;
        k_d          = 8'd0;
        state_d      = S_PACK;
        if (exp_f == 8'd0) begin
          spec_flags_d = {3'b000, (mant != 23'd0)};
        end else if (exp_f == 8'hFF) begin
          if (mant != 23'd0) begin
            spec_flags_d = 4'b1000;
          end else begin
            spec_fixed_d = sat_val;
            spec_flags_d = 4'b0100;
          end
        end else if (e_unb >= INT_LIM) begin
          spec_fixed_d = sat_val;
          if (!(sign && (e_unb == INT_LIM) && (mant == 23'd0))) begin
            spec_flags_d = 4'b0011;
          end
        end else begin
          spec_d  = 1'b0;
          acc_d   = {{(AW-24){1'b0}}, 1'b1, mant};
          left_d  = (s_val > 11'sd0);
          state_d = S_SHIFT;
          if (s_val > 11'sd0) begin
            k_d = s_val[7:0];
          end else begin
            k_d = (neg_s > 11'sd26) ? 8'd26 : neg_s[7:0];
          end
        end
      end

      S_SHIFT: begin
        if (k_q == 8'd0) begin
          state_d = S_PACK;
        end else begin
          k_d = k_q - 8'd1;
          if (left_q) begin
            acc_d = {acc_q[AW-2:0], 1'b0};
          end else begin
            acc_d    = {1'b0, acc_q[AW-1:1]};
            guard_d  = acc_q[0];
            sticky_d = sticky_q | guard_q;
          end
        end
      end

      S_PACK: begin
        state_d = S_DONE;
        if (spec_q) begin
          fixed_d = spec_fixed_q;
          flags_d = spec_flags_q;
        end else if (mag_r > lim) begin
          fixed_d = sat_val;
          flags_d = 4'b0011;
        end else begin
          fixed_d = sign ? (~mag_r[W-1:0] + 1'b1) : mag_r[W-1:0];
          flags_d = {3'b000, (guard_q | sticky_q)};
        end
      end

      S_DONE: begin
        if (bus_io.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      f_q          <= '0;
      acc_q        <= '0;
      k_q          <= '0;
      left_q       <= 1'b0;
      guard_q      <= 1'b0;
      sticky_q     <= 1'b0;
      spec_q       <= 1'b0;
      spec_fixed_q <= '0;
      spec_flags_q <= '0;
      fixed_q      <= '0;
      flags_q      <= '0;
    end else begin
      state_q      <= state_d;
      f_q          <= f_d;
      acc_q        <= acc_d;
      k_q          <= k_d;
      left_q       <= left_d;
      guard_q      <= guard_d;
      sticky_q     <= sticky_d;
      spec_q       <= spec_d;
      spec_fixed_q <= spec_fixed_d;
      spec_flags_q <= spec_flags_d;
      fixed_q      <= fixed_d;
      flags_q      <= flags_d;
    end
  end
endmodule

// File: tb/tb_fp32_to_fixed.sv
// Directed + random checks of fp32_to_fixed (INT_W=16, FRAC_W=16) through a scoreboard queue.
// Honours ROUND_NEAREST_EN the same way the design does.
module tb_fp32_to_fixed;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  fp32_to_fixed_if #(.W(W)) bus ();

  fp32_to_fixed #(.INT_W(16), .FRAC_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_io      (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  logic [W+3:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference: whole-word shift on 64-bit integers, remainder-based rounding.
  function automatic logic [W+3:0] model(input logic [31:0] f);
    logic        sgn;
    int          e;
    int          s;
    logic [22:0] m;
    logic [63:0] mag, q, rem, half;
    logic        inx;
    logic [31:0] r;
    sgn = f[31];
    e   = int'(f[30:23]);
    m   = f[22:0];
    if (e == 0) return {32'h0, 3'b000, (m != 23'd0)};
    if (e == 255) return (m != 23'd0) ? {32'h0, 4'b1000}
                                      : {(sgn ? 32'h8000_0000 : 32'h7FFF_FFFF), 4'b0100};
    if (e - 127 >= 15) begin
      if (sgn && (e - 127 == 15) && (m == 23'd0)) return {32'h8000_0000, 4'b0000};
      return {(sgn ? 32'h8000_0000 : 32'h7FFF_FFFF), 4'b0011};
    end
    mag = {40'h0, 1'b1, m};
    s   = e - 134;
    rem = 64'd0;
    half = 64'd0;
    if (s >= 0) begin
      q = mag << s;
    end else if (-s > 40) begin
      q = 64'd0;
      rem = mag;
      half = 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      q    = mag >> (-s);
      rem  = mag & ((64'd1 << (-s)) - 64'd1);
      half = 64'd1 << (-s - 1);
    end
    inx = (rem != 64'd0);
`ifdef ROUND_NEAREST_EN
    if ((rem > half) || ((rem == half) && q[0])) q = q + 64'd1;
`endif
    r = sgn ? (~q[31:0] + 32'd1) : q[31:0];
    return {r, 3'b000, inx};
  endfunction

  // Offer one operand, push its expected result, return #1 after the accepting edge.
  task automatic drive(input logic [31:0] f, input logic [W+3:0] exp);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready", 64'(bus.in_ready), 64'd1);
    exp_q.push_back(exp);
    bus.in_valid = 1'b1;
    bus.in_float = f;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait for out_valid, compare against the scoreboard head, report cycles since accept.
  task automatic collect(input string tag, output int lat);
    logic [W+3:0] exp;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!bus.out_valid && lat < 200);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      exp = exp_q.pop_front();
      check(tag, 64'({bus.out_fixed, bus.out_flags}), 64'(exp));
    end
  endtask

  task automatic finish_hs();
    @(posedge clk); #1;
  endtask

  task automatic convert(input string tag, input logic [31:0] f, input logic [W+3:0] exp);
    int lat;
    drive(f, exp);
    collect(tag, lat);
    finish_hs();
  endtask

  initial begin
    int lat;
    int n;
    logic [31:0] rf;
    logic [31:0] rm;
    logic [7:0]  re;
    logic        saw_valid;
    logic [W+3:0] exp01;

`ifdef ROUND_NEAREST_EN
    exp01 = {32'h0000_199A, 4'b0001};
`else
    exp01 = {32'h0000_1999, 4'b0001};
`endif

    bus.in_valid  = 1'b0;
    bus.in_float  = 32'h0;
    bus.out_ready = 1'b1;

    // Reset state while rst is held
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_fixed", 64'(bus.out_fixed), 64'd0);
    check("rst_out_flags", 64'(bus.out_flags), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 3.5 with latency: k=6 so out_valid rises 9 edges after accept
    drive(32'h4060_0000, {32'h0003_8000, 4'b0000});
    collect("conv_3p5", lat);
    check("lat_3p5", 64'(lat), 64'd9);
    finish_hs();

    drive(32'hC2C8_0000, {32'hFF9C_0000, 4'b0000});
    collect("conv_m100", lat);
    check("lat_m100", 64'(lat), 64'd4);
    finish_hs();

    convert("conv_pzero", 32'h0000_0000, {32'h0, 4'b0000});
    convert("conv_nzero", 32'h8000_0000, {32'h0, 4'b0000});
    convert("conv_1e6",   32'h4974_2400, {32'h7FFF_FFFF, 4'b0011});
    convert("conv_m1e6",  32'hC974_2400, {32'h8000_0000, 4'b0011});
    convert("conv_m32768",32'hC700_0000, {32'h8000_0000, 4'b0000});
    convert("conv_p32768",32'h4700_0000, {32'h7FFF_FFFF, 4'b0011});
    convert("conv_nan",   32'h7FC0_0000, {32'h0, 4'b1000});
    convert("conv_pinf",  32'h7F80_0000, {32'h7FFF_FFFF, 4'b0100});
    convert("conv_ninf",  32'hFF80_0000, {32'h8000_0000, 4'b0100});
    convert("conv_denorm",32'h0000_0001, {32'h0, 4'b0001});
    convert("conv_0p1",   32'h3DCC_CCCD, exp01);
    convert("conv_tiny",  32'h3000_0000, {32'h0, 4'b0001});
    convert("conv_one",   32'h3F80_0000, {32'h0001_0000, 4'b0000});

    // Random normal operands well inside range, checked against the model
    for (int i = 0; i < 12; i++) begin
      rm = $urandom();
      re = 8'($urandom_range(141, 100));
      rf = {1'($urandom_range(1, 0)), re, rm[22:0]};
      convert("conv_rand", rf, model(rf));
    end

    // Back-pressure: DONE holds its outputs and ignores new operands
    bus.out_ready = 1'b0;
    drive(32'h4060_0000, {32'h0003_8000, 4'b0000});
    collect("hold_first", lat);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_float = 32'h3F80_0000;
      @(posedge clk); #1;
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_data",  64'({bus.out_fixed, bus.out_flags}), 64'({32'h0003_8000, 4'b0000}));
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", 64'(bus.out_valid), 64'd0);
    check("release_in_ready", 64'(bus.in_ready), 64'd1);

    // Reset during SHIFT aborts the conversion
    drive(32'h4060_0000, {32'h0003_8000, 4'b0000});
    n = 0;
    while (dbg_state != 3'd2 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("reach_shift", 64'(dbg_state), 64'd2);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_in_ready",  64'(bus.in_ready),  64'd1);
    #1 rst = 1'b0;
    void'(exp_q.pop_back());
    saw_valid = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check("abort_no_result", 64'(saw_valid), 64'd0);
    convert("after_abort_0p1", 32'h3DCC_CCCD, exp01);
    convert("after_abort_m100", 32'hC2C8_0000, {32'hFF9C_0000, 4'b0000});

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
